// File: rtl/alu_share_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_pkg
// Shared definitions for the ALU sharing arbiter:
//   - ALU_OP_* opcode constants, matching the encoding the ALU decodes
//   - ARB_PORTS: number of requesters sharing the ALU
//   - buf_state_t: per-port response buffer state (EMPTY / FULL)
// No ports; imported by alu_arb_resp_buf and alu_share_arbiter.
// -----------------------------------------------------------------------------
package alu_share_arbiter_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'h4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = 4'h5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL  = 4'h6;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRA  = 4'h7;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = 4'h8;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = 4'h9;

  localparam int ARB_PORTS = 2;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/alu_arb_resp_buf.sv
// -----------------------------------------------------------------------------
// alu_arb_resp_buf
// One-entry response register for a single arbiter port.
//
// Handshake: a response transfers on a cycle where the buffer is FULL and
// resp_ready is high. A new capture in that same cycle refills the buffer
// (back-to-back), so a port can sustain one op per cycle while its consumer
// keeps resp_ready high. While FULL and !resp_ready, data is held stable.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid       request valid of this port (for eligibility)
//   capture         grant for this port: load result/less/zero this edge
//   result_in       ALU result to capture
//   less_in         ALU less flag to capture
//   zero_in         ALU zero flag to capture
//   resp_ready      consumer accepts the buffered response
//   eligible        port may be granted this cycle
//   state           buffer FSM state (EMPTY/FULL); FULL means response valid
//   resp_result     buffered result
//   resp_less       buffered less flag
//   resp_zero       buffered zero flag
// -----------------------------------------------------------------------------
module alu_arb_resp_buf
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                capture,
  input  logic [DATA_LEN-1:0] result_in,
  input  logic                less_in,
  input  logic                zero_in,
  input  logic                resp_ready,
  output logic                eligible,
  output buf_state_t          state,
  output logic [DATA_LEN-1:0] resp_result,
  output logic                resp_less,
  output logic                resp_zero
);

  buf_state_t state_q;
  buf_state_t state_d;

  // The slot frees up in the same cycle the consumer drains it, which is
  // what allows back-to-back grants to a port with resp_ready held high.
  assign eligible = req_valid && ((state_q == BUF_EMPTY) || resp_ready);
  assign state    = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY: if (capture) state_d = BUF_FULL;
      BUF_FULL:  if (resp_ready && !capture) state_d = BUF_EMPTY;
      default:   state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_result <= '0;
      resp_less   <= 1'b0;
      resp_zero   <= 1'b0;
    end else if (capture) begin
      resp_result <= result_in;
      resp_less   <= less_in;
      resp_zero   <= zero_in;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between port 0 (EXU) and port 1 (branch /
// compare unit). At most one request is granted per cycle by round-robin;
// the granted operands/opcode drive the ALU in the same cycle and the ALU
// outputs are registered into that port's response buffer, giving a fixed
// 1-cycle latency from request accept to response valid.
//
// Handshake semantics (all channels): a transfer happens on a rising clk
// edge where valid and ready are both high. Requesters hold req fields
// stable while valid && !ready. reqN_ready is combinational from the
// current-cycle inputs and state, and is forced low while rst is high.
//
// Optional feature (macro ALU_ARB_STAT_EN): adds free-running 32-bit
// counters stat_grant0 / stat_grant1 (grants per port) and stat_conflict
// (cycles where both ports were eligible). They wrap and clear on rst.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/ready              port N request handshake
//   reqN_src1/src2/op             port N operands and ALU opcode
//   respN_valid/ready             port N response handshake
//   respN_result/less/zero        port N registered ALU outputs
//   alu_src1/src2/control         drive to shared ALU (0/0/ADD when idle)
//   alu_result/less/zero          from shared ALU
//   stat_grant0/1, stat_conflict  statistics (ALU_ARB_STAT_EN only)
// -----------------------------------------------------------------------------
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int OP_LEN   = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_LEN-1:0] req0_src1,
  input  logic [DATA_LEN-1:0] req0_src2,
  input  logic [OP_LEN-1:0]   req0_op,
  output logic                resp0_valid,
  input  logic                resp0_ready,
  output logic [DATA_LEN-1:0] resp0_result,
  output logic                resp0_less,
  output logic                resp0_zero,

  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_LEN-1:0] req1_src1,
  input  logic [DATA_LEN-1:0] req1_src2,
  input  logic [OP_LEN-1:0]   req1_op,
  output logic                resp1_valid,
  input  logic                resp1_ready,
  output logic [DATA_LEN-1:0] resp1_result,
  output logic                resp1_less,
  output logic                resp1_zero,

  output logic [DATA_LEN-1:0] alu_src1,
  output logic [DATA_LEN-1:0] alu_src2,
  output logic [OP_LEN-1:0]   alu_control,
  input  logic [DATA_LEN-1:0] alu_result,
  input  logic                alu_less,
  input  logic                alu_zero
`ifdef ALU_ARB_STAT_EN
  ,
  output logic [31:0]         stat_grant0,
  output logic [31:0]         stat_grant1,
  output logic [31:0]         stat_conflict
`endif
);

  logic [ARB_PORTS-1:0] eligible;
  logic [ARB_PORTS-1:0] grant;
  buf_state_t           state0;
  buf_state_t           state1;

  // Port that won the most recent grant; resets to 1 so port 0 wins the
  // first tie.
  logic last_grant_q;
  logic last_grant_d;

  // ---------------------------------------------------------------------------
  // Response buffers
  // ---------------------------------------------------------------------------
  alu_arb_resp_buf #(.DATA_LEN(DATA_LEN)) u_buf0 (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req0_valid),
    .capture     (grant[0]),
    .result_in   (alu_result),
    .less_in     (alu_less),
    .zero_in     (alu_zero),
    .resp_ready  (resp0_ready),
    .eligible    (eligible[0]),
    .state       (state0),
    .resp_result (resp0_result),
    .resp_less   (resp0_less),
    .resp_zero   (resp0_zero)
  );

  alu_arb_resp_buf #(.DATA_LEN(DATA_LEN)) u_buf1 (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req1_valid),
    .capture     (grant[1]),
    .result_in   (alu_result),
    .less_in     (alu_less),
    .zero_in     (alu_zero),
    .resp_ready  (resp1_ready),
    .eligible    (eligible[1]),
    .state       (state1),
    .resp_result (resp1_result),
    .resp_less   (resp1_less),
    .resp_zero   (resp1_zero)
  );

  assign resp0_valid = (state0 == BUF_FULL);
  assign resp1_valid = (state1 == BUF_FULL);

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------------
  // Grants are suppressed during reset so nothing is accepted into a buffer
  // that the same edge is clearing.
  always_comb begin
    grant        = '0;
    last_grant_d = last_grant_q;
    if (!rst) begin
      if (eligible[0] && (!eligible[1] || last_grant_q)) begin
        grant[0] = 1'b1;
      end else if (eligible[1]) begin
        grant[1] = 1'b1;
      end
    end
    if (grant[0]) begin
      last_grant_d = 1'b0;
    end else if (grant[1]) begin
      last_grant_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // ---------------------------------------------------------------------------
  // ALU operand mux; idle drive is a harmless 0 + 0 ADD
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_src1    = '0;
    alu_src2    = '0;
    alu_control = OP_LEN'(ALU_OP_ADD);
    if (grant[0]) begin
      alu_src1    = req0_src1;
      alu_src2    = req0_src2;
      alu_control = req0_op;
    end else if (grant[1]) begin
      alu_src1    = req1_src1;
      alu_src2    = req1_src2;
      alu_control = req1_op;
    end
  end

`ifdef ALU_ARB_STAT_EN
  // ---------------------------------------------------------------------------
  // Statistics counters (wrap at 2^32)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (grant[0]) stat_grant0 <= stat_grant0 + 32'd1;
      if (grant[1]) stat_grant1 <= stat_grant1 + 32'd1;
      if (&eligible) stat_conflict <= stat_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
// Self-checking bench for alu_share_arbiter. A behavioural ALU model sits on
// the alu_* interface. A monitor pushes the expected response whenever a
// request is accepted and pops/compares it when the response is taken.
// Directed table vectors and hand-written sequences cover reset, round-robin
// ties, backpressure, the zero flag and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int DL = 32;
  localparam int OL = 4;
  localparam int W  = DL + 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req0_valid, req0_ready;
  logic [DL-1:0] req0_src1, req0_src2;
  logic [OL-1:0] req0_op;
  logic          resp0_valid, resp0_ready;
  logic [DL-1:0] resp0_result;
  logic          resp0_less, resp0_zero;
  logic          req1_valid, req1_ready;
  logic [DL-1:0] req1_src1, req1_src2;
  logic [OL-1:0] req1_op;
  logic          resp1_valid, resp1_ready;
  logic [DL-1:0] resp1_result;
  logic          resp1_less, resp1_zero;
  logic [DL-1:0] alu_src1, alu_src2, alu_result;
  logic [OL-1:0] alu_control;
  logic          alu_less, alu_zero;

  alu_share_arbiter #(.DATA_LEN(DL), .OP_LEN(OL)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_src1    (req0_src1),
    .req0_src2    (req0_src2),
    .req0_op      (req0_op),
    .resp0_valid  (resp0_valid),
    .resp0_ready  (resp0_ready),
    .resp0_result (resp0_result),
    .resp0_less   (resp0_less),
    .resp0_zero   (resp0_zero),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_src1    (req1_src1),
    .req1_src2    (req1_src2),
    .req1_op      (req1_op),
    .resp1_valid  (resp1_valid),
    .resp1_ready  (resp1_ready),
    .resp1_result (resp1_result),
    .resp1_less   (resp1_less),
    .resp1_zero   (resp1_zero),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_control  (alu_control),
    .alu_result   (alu_result),
    .alu_less     (alu_less),
    .alu_zero     (alu_zero)
  );

  // ---------------------------------------------------------------------------
  // ALU model: {result, less, zero}
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] alu_model(logic [DL-1:0] a, logic [DL-1:0] b,
                                             logic [OL-1:0] op);
    logic [DL-1:0] r;
    logic          l;
    case (op)
      ALU_OP_ADD:  r = a + b;
      ALU_OP_SUB:  r = a - b;
      ALU_OP_AND:  r = a & b;
      ALU_OP_OR:   r = a | b;
      ALU_OP_XOR:  r = a ^ b;
      ALU_OP_SLL:  r = a << b[4:0];
      ALU_OP_SRL:  r = a >> b[4:0];
      ALU_OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      ALU_OP_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
      ALU_OP_SLTU: r = {31'b0, (a < b)};
      default:     r = '0;
    endcase
    l = (op == ALU_OP_SLTU) ? (a < b) : ($signed(a) < $signed(b));
    return {r, l, (r == '0)};
  endfunction

  always_comb begin
    {alu_result, alu_less, alu_zero} = alu_model(alu_src1, alu_src2, alu_control);
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [95:0] act, logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  always @(negedge clk) begin
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      // Responses taken this cycle come from earlier grants: pop first.
      if (resp0_valid && resp0_ready) begin
        if (exp_q0.size() == 0) check("sb0_unexpected", 96'(resp0_valid), 96'(0));
        else check("sb0_resp", 96'({resp0_result, resp0_less, resp0_zero}),
                   96'(exp_q0.pop_front()));
      end
      if (resp1_valid && resp1_ready) begin
        if (exp_q1.size() == 0) check("sb1_unexpected", 96'(resp1_valid), 96'(0));
        else check("sb1_resp", 96'({resp1_result, resp1_less, resp1_zero}),
                   96'(exp_q1.pop_front()));
      end
      if (req0_ready && req1_ready) check("one_grant", 96'({req0_ready, req1_ready}), 96'(1));
      if (req0_ready) begin
        check("alu_drive0", 96'({alu_src1, alu_src2, alu_control}),
              96'({req0_src1, req0_src2, req0_op}));
        exp_q0.push_back(alu_model(req0_src1, req0_src2, req0_op));
      end else if (req1_ready) begin
        check("alu_drive1", 96'({alu_src1, alu_src2, alu_control}),
              96'({req1_src1, req1_src2, req1_op}));
        exp_q1.push_back(alu_model(req1_src1, req1_src2, req1_op));
      end else begin
        check("alu_idle", 96'({alu_src1, alu_src2, alu_control}),
              96'({32'd0, 32'd0, ALU_OP_ADD}));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: single request on one port, checked against table constants
  // ---------------------------------------------------------------------------
  task automatic do_op(input int p, input logic [DL-1:0] a, input logic [DL-1:0] b,
                       input logic [OL-1:0] op, input logic [DL-1:0] er,
                       input logic el, input logic ez, input string name);
    bit got;
    got = 1'b0;
    if (p == 0) begin
      req0_src1 = a; req0_src2 = b; req0_op = op; req0_valid = 1'b1; resp0_ready = 1'b1;
    end else begin
      req1_src1 = a; req1_src2 = b; req1_op = op; req1_valid = 1'b1; resp1_ready = 1'b1;
    end
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? req0_ready : req1_ready) got = 1'b1;
    end
    check({name, "_grant"}, 96'(got), 96'(1));
    check({name, "_alu_op"}, 96'(alu_control), 96'(op));
    next_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    if (p == 0) begin
      check({name, "_valid"}, 96'(resp0_valid), 96'(1));
      check({name, "_resp"}, 96'({resp0_result, resp0_less, resp0_zero}), 96'({er, el, ez}));
    end else begin
      check({name, "_valid"}, 96'(resp1_valid), 96'(1));
      check({name, "_resp"}, 96'({resp1_result, resp1_less, resp1_zero}), 96'({er, el, ez}));
    end
  endtask

  typedef struct {
    int            port;
    logic [DL-1:0] src1;
    logic [DL-1:0] src2;
    logic [OL-1:0] op;
    logic [DL-1:0] exp_result;
    logic          exp_less;
    logic          exp_zero;
  } vec_t;

  vec_t vecs[8];

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    vecs[0] = '{0, 32'd5,          32'd3,          ALU_OP_SUB,  32'd2,          1'b0, 1'b0};
    vecs[1] = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  ALU_OP_SUB,  32'd0,          1'b0, 1'b1};
    vecs[2] = '{0, 32'd7,          32'd9,          ALU_OP_SUB,  32'hFFFF_FFFE,  1'b1, 1'b0};
    vecs[3] = '{1, 32'hFFFF_FFFF,  32'd1,          ALU_OP_SLT,  32'd1,          1'b1, 1'b0};
    vecs[4] = '{0, 32'h0000_F0F0,  32'h0000_0FF0,  ALU_OP_AND,  32'h0000_00F0,  1'b0, 1'b0};
    vecs[5] = '{1, 32'd1,          32'd4,          ALU_OP_SLL,  32'd16,         1'b1, 1'b0};
    vecs[6] = '{0, 32'd0,          32'd0,          ALU_OP_ADD,  32'd0,          1'b0, 1'b1};
    vecs[7] = '{1, 32'h8000_0000,  32'd1,          ALU_OP_SLTU, 32'd0,          1'b0, 1'b1};

    // Reset with both requesters already asking.
    rst = 1'b1;
    req0_valid = 1'b1; req0_src1 = 32'd1; req0_src2 = 32'd1; req0_op = ALU_OP_ADD;
    req1_valid = 1'b1; req1_src1 = 32'hFFFF_FFFF; req1_src2 = 32'd1; req1_op = ALU_OP_SLT;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_req0_ready", 96'(req0_ready), 96'(0));
      check("rst_resp_valid", 96'({resp0_valid, resp1_valid}), 96'(0));
    end
    check("rst_resp_data", 96'({resp0_result, resp0_less, resp0_zero,
                                 resp1_result, resp1_less, resp1_zero}), 96'(0));
    next_cycle();
    rst = 1'b0;

    // Tie: port 0 first, then strict alternation.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_grant", 96'({req0_ready, req1_ready}), (i % 2 == 0) ? 96'(2) : 96'(1));
      next_cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("rr_resp1", 96'({resp1_valid, resp1_result, resp1_less}), 96'({1'b1, 32'd1, 1'b1}));
    check("rr_resp0_drained", 96'(resp0_valid), 96'(0));
    next_cycle();

    // Table-driven single operations.
    foreach (vecs[i]) begin
      do_op(vecs[i].port, vecs[i].src1, vecs[i].src2, vecs[i].op,
            vecs[i].exp_result, vecs[i].exp_less, vecs[i].exp_zero,
            $sformatf("vec%0d", i));
      next_cycle();
    end

    // Backpressure on port 0 while port 1 streams.
    resp0_ready = 1'b0; resp1_ready = 1'b1;
    req0_valid = 1'b1; req0_src1 = 32'd10; req0_src2 = 32'd20; req0_op = ALU_OP_ADD;
    @(negedge clk);
    check("bp_first_grant", 96'(req0_ready), 96'(1));
    next_cycle();
    req0_src1 = 32'd3; req0_src2 = 32'd4;
    req1_valid = 1'b1; req1_src1 = 32'd9; req1_src2 = 32'd4; req1_op = ALU_OP_SUB;
    repeat (3) begin
      @(negedge clk);
      check("bp_grants", 96'({req0_ready, req1_ready}), 96'(1));
      check("bp_hold", 96'({resp0_valid, resp0_result}), 96'({1'b1, 32'd30}));
      next_cycle();
    end
    resp0_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", 96'({req0_ready, req1_ready}), 96'(2));
    next_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("bp_second_resp", 96'({resp0_valid, resp0_result}), 96'({1'b1, 32'd7}));
    next_cycle();

    // Reset while port 1 holds an undrained response.
    resp1_ready = 1'b0;
    req1_valid = 1'b1; req1_src1 = 32'd8; req1_src2 = 32'd3; req1_op = ALU_OP_SUB;
    @(negedge clk);
    check("mid_rst_grant", 96'(req1_ready), 96'(1));
    next_cycle();
    rst = 1'b1;
    req1_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_cleared", 96'({resp1_valid, resp1_result}), 96'(0));
    next_cycle();

    check("sb0_drain", 96'(exp_q0.size()), 96'(0));
    check("sb1_drain", 96'(exp_q1.size()), 96'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational ALU between two requesters: port 0 is EXU and port 1 is the branch/compare unit. Each port uses a valid/ready request channel and a valid/ready response channel. The block picks at most one request per cycle by round-robin, drives the ALU operands and opcode, and registers result, less and zero into a per-port response buffer. Fixed latency is 1 cycle from request accept to response valid.

Parameters:
DATA_LEN, 32, operand/result width
OP_LEN, 4, ALU opcode width (ALU_OP_* encoding)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
reqN_valid  in  1  port N (N=0,1) request valid
reqN_ready  out  1  port N request accepted this cycle when valid&ready
reqN_src1  in  DATA_LEN  operand 1
reqN_src2  in  DATA_LEN  operand 2
reqN_op  in  OP_LEN  ALU opcode
respN_valid  out  1  port N response valid
respN_ready  in  1  port N consumer accepts response
respN_result  out  DATA_LEN  registered ALU result
respN_less  out  1  registered less flag
respN_zero  out  1  registered zero flag
alu_src1  out  DATA_LEN  to ALU src1
alu_src2  out  DATA_LEN  to ALU src2
alu_control  out  OP_LEN  to ALU opcode
alu_result  in  DATA_LEN  from ALU
alu_less  in  1  from ALU
alu_zero  in  1  from ALU

Behaviour:
- Reset (rst=1 at a clk edge): resp0_valid=resp1_valid=0; resp results and flags=0; last_grant=1, so port 0 wins the first tie. Reset mid-operation discards any buffered response and any in-flight grant.
- Response buffer per port has two states: EMPTY and FULL.
  - EMPTY->FULL on grant.
  - FULL->EMPTY on respN_ready with no new grant.
  - FULL->FULL on respN_ready with a new grant (back-to-back).
  - FULL and !respN_ready holds data stable.
- Port N is eligible when reqN_valid and (buffer EMPTY or respN_ready). reqN_ready = grantN, purely combinational from the current-cycle inputs and state.
- Arbitration:
  - One eligible port: it is granted.
  - Both eligible: the port != last_grant is granted.
  - last_grant updates only on a grant.
- ALU drive:
  - On a grant, alu_* equals the granted port's src1/src2/op in the same cycle.
  - With no grant, alu_src1=alu_src2=0 and alu_control=ALU_OP_ADD.
- Capture: on a grant edge, alu_result/alu_less/alu_zero are written into the granted port's buffer, and respN_valid=1 the next cycle.
- Throughput: 1 op/cycle total. A single port reaches 1 op/cycle when its resp_ready is held high.
- Port with FULL buffer and resp_ready=0: reqN_ready=0 and the other port may be granted. No request is lost while valid is held.
- Requesters must hold reqN_* stable while valid and !ready. The block does not check this.

Optional Feature:
ALU_ARB_STAT_EN
- Defined: adds outputs stat_grant0, stat_grant1 and stat_conflict (each 32 bits). They count grants per port and cycles where both ports were eligible. They wrap at 2^32, reset to 0 on rst, and saturation is not applied.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package/define file holds the ALU_OP_* opcode constants (already used by the ALU), plus ARB_PORTS=2 and the response-buffer state encoding (EMPTY=1'b0, FULL=1'b1).
- One sub-module, alu_arb_resp_buf, instantiated per port: the 1-entry response register with valid/ready handshake, capture enable, and an eligible output.

Test Plan:
- Reset: rst high 2 cycles with req0_valid=1 -> resp0_valid=resp1_valid=0, req0_ready=0 during reset. After release, first grant goes to port 0.
- Single op: req0 src1=5, src2=3, op=ALU_OP_SUB, resp0_ready=1 -> same cycle alu_control=SUB and req0_ready=1. Next cycle resp0_valid=1, result=2, zero=0, less=0.
- Tie and round-robin: both valid every cycle with resp ready high. Port 0 does ADD 1+1, port 1 does SLT signed -1 vs 1 -> grants alternate 0,1,0,1. Port 1 response has result=1 and less=1.
- Backpressure: resp0_ready=0 after a completed port-0 op, req0 and req1 valid -> req0_ready=0, port 1 granted every cycle, resp0 holds its value. When resp0_ready rises, port 0 is granted that same cycle.
- Zero flag: req1 src1=src2=32'hFFFF_FFFF with op=ALU_OP_SUB -> resp1_zero=1, result=0.
- Mid-op reset: grant port 1, assert rst the next cycle -> resp1_valid=0 and the buffered result is cleared to 0.
